// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle FETCH -> READ -> EXEC control FSM owning PC, Z/C flags,
//   skip-pending and interrupt entry/return state.
// Latency: 3 cycles per instruction minimum, plus one cycle per fetch wait state.
// Backpressure: fetch_req is held in FETCH until fetch_ack; no other stall source.
// Ports: clk/reset_n; fetch interface (pc, fetch_req, fetch_ack, instr_in); decoded
//   ALU fields (alu_opcode/direction/selector/operand, reg_raddr, alu_cin); ALU request
//   inputs gated into accum_we/reg_we; flags z_flag/c_flag; int_req/int_ack/int_en.
module exec_sequencer #(
  parameter int PC_WIDTH     = 12,
  parameter int RESET_VECTOR = 0,
  parameter int INT_VECTOR   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_req,
  input  logic                fetch_ack,
  input  logic [15:0]         instr_in,
  output logic [3:0]          alu_opcode,
  output logic                alu_direction,
  output logic [2:0]          alu_selector,
  output logic [7:0]          alu_operand,
  output logic [7:0]          reg_raddr,
  output logic                alu_cin,
  input  logic                alu_accum_write,
  input  logic                alu_reg_write,
  input  logic                alu_z_write,
  input  logic                alu_c_write,
  input  logic                alu_zout,
  input  logic                alu_cout,
  input  logic                alu_retint,
  input  logic                alu_skip,
  output logic                accum_we,
  output logic                reg_we,
  output logic                z_flag,
  output logic                c_flag,
  input  logic                int_req,
  output logic                int_ack,
  output logic                int_en
);

  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] INT_PC = PC_WIDTH'(INT_VECTOR);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic [15:0]         instr_q, instr_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic                skip_q, skip_d;
  logic                int_en_q, int_en_d;
  logic                int_ack_q, int_ack_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic                int_take;
  logic                in_exec;

  // Natural wrap modulo 2^PC_WIDTH.
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign in_exec = (state_q == S_EXEC);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    instr_d   = instr_q;
    z_d       = z_q;
    c_d       = c_q;
    skip_d    = skip_q;
    int_en_d  = int_en_q;
    int_ack_d = 1'b0;
    int_take  = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (fetch_ack) begin
          instr_d = instr_in;
          if (skip_q) begin
            // Skipped slot: consume the word without executing it. This is also an
            // instruction boundary, so an interrupt deferred by the skip enters here.
            skip_d   = 1'b0;
            pc_d     = pc_inc;
            int_take = int_req && int_en_q;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (alu_z_write) z_d = alu_zout;
        if (alu_c_write) c_d = alu_cout;
        skip_d = alu_skip;
        if (alu_retint) begin
          pc_d     = epc_q;
          int_en_d = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
        // A skip must consume its slot first; a return must land before re-entry.
        int_take = int_req && int_en_q && !alu_skip && !alu_retint;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Entry overrides only the PC; the instruction's own commits above still stand.
    if (int_take) begin
      epc_d     = pc_inc;
      pc_d      = INT_PC;
      int_en_d  = 1'b0;
      int_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RST_PC;
      epc_q     <= RST_PC;
      instr_q   <= 16'h0000;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      skip_q    <= 1'b0;
      int_en_q  <= 1'b1;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      instr_q   <= instr_d;
      z_q       <= z_d;
      c_q       <= c_d;
      skip_q    <= skip_d;
      int_en_q  <= int_en_d;
      int_ack_q <= int_ack_d;
    end
  end

  assign pc            = pc_q;
  // State resets to FETCH, so the request is masked while reset is held.
  assign fetch_req     = (state_q == S_FETCH) && reset_n;
  assign alu_opcode    = instr_q[15:12];
  assign alu_direction = instr_q[11];
  assign alu_selector  = instr_q[10:8];
  assign alu_operand   = instr_q[7:0];
  assign reg_raddr     = instr_q[7:0];
  assign alu_cin       = c_q;
  // ALU requests are only honoured in the single EXEC cycle.
  assign accum_we      = in_exec && alu_accum_write;
  assign reg_we        = in_exec && alu_reg_write;
  assign z_flag        = z_q;
  assign c_flag        = c_q;
  assign int_ack       = int_ack_q;
  assign int_en        = int_en_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed vectors for exec_sequencer with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// The bench plays instruction memory and ALU; fetch_ack timing is fully directed.
module tb_exec_sequencer;

  logic        clk;
  logic        reset_n;
  logic [11:0] pc;
  logic        fetch_req;
  logic        fetch_ack;
  logic [15:0] instr_in;
  logic [3:0]  alu_opcode;
  logic        alu_direction;
  logic [2:0]  alu_selector;
  logic [7:0]  alu_operand;
  logic [7:0]  reg_raddr;
  logic        alu_cin;
  logic        alu_accum_write, alu_reg_write, alu_z_write, alu_c_write;
  logic        alu_zout, alu_cout, alu_retint, alu_skip;
  logic        accum_we, reg_we, z_flag, c_flag;
  logic        int_req, int_ack, int_en;

  int n_vec = 0;
  int n_err = 0;

  exec_sequencer #(.PC_WIDTH(12), .RESET_VECTOR(0), .INT_VECTOR(4)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .instr_in(instr_in), .alu_opcode(alu_opcode), .alu_direction(alu_direction),
    .alu_selector(alu_selector), .alu_operand(alu_operand), .reg_raddr(reg_raddr),
    .alu_cin(alu_cin), .alu_accum_write(alu_accum_write), .alu_reg_write(alu_reg_write),
    .alu_z_write(alu_z_write), .alu_c_write(alu_c_write), .alu_zout(alu_zout),
    .alu_cout(alu_cout), .alu_retint(alu_retint), .alu_skip(alu_skip),
    .accum_we(accum_we), .reg_we(reg_we), .z_flag(z_flag), .c_flag(c_flag),
    .int_req(int_req), .int_ack(int_ack), .int_en(int_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_alu();
    alu_accum_write = 1'b0; alu_reg_write = 1'b0; alu_z_write = 1'b0; alu_c_write = 1'b0;
    alu_zout = 1'b0; alu_cout = 1'b0; alu_retint = 1'b0; alu_skip = 1'b0;
  endtask

  // ALU write requests are raised outside EXEC to prove they are masked.
  task automatic chk_no_strobe(input string tag);
    alu_accum_write = 1'b1; alu_reg_write = 1'b1;
    #1;
    chk({tag, "_accum_we"}, 32'(accum_we), 32'd0);
    chk({tag, "_reg_we"}, 32'(reg_we), 32'd0);
    alu_accum_write = 1'b0; alu_reg_write = 1'b0;
  endtask

  // Holds a FETCH for 'waits' cycles, then acks with 'ins'. Returns one cycle later.
  task automatic do_fetch(input int waits, input logic [15:0] ins, input logic [11:0] exp_pc);
    for (int i = 0; i < waits; i++) begin
      fetch_ack = 1'b0;
      chk_no_strobe("wait");
      chk("wait_fetch_req", 32'(fetch_req), 32'd1);
      chk("wait_pc", 32'(pc), 32'(exp_pc));
      tick();
    end
    fetch_ack = 1'b1;
    instr_in  = ins;
    #1;
    chk("fetch_req", 32'(fetch_req), 32'd1);
    chk("fetch_pc", 32'(pc), 32'(exp_pc));
    tick();
    fetch_ack = 1'b0;
    instr_in  = 16'h0000;
  endtask

  task automatic run_instr(input int waits, input logic [15:0] ins, input logic [11:0] exp_pc,
                           input logic aw, input logic rw, input logic zw, input logic cw,
                           input logic zo, input logic co, input logic ret, input logic sk);
    logic [7:0] op8;
    op8 = ins[7:0];
    do_fetch(waits, ins, exp_pc);
    // READ
    chk_no_strobe("rd");
    chk("rd_fetch_req", 32'(fetch_req), 32'd0);
    chk("rd_raddr", 32'(reg_raddr), 32'(op8));
    chk("rd_fields", 32'({alu_opcode, alu_direction, alu_selector, alu_operand}), 32'(ins));
    tick();
    // EXEC
    alu_accum_write = aw; alu_reg_write = rw; alu_z_write = zw; alu_c_write = cw;
    alu_zout = zo; alu_cout = co; alu_retint = ret; alu_skip = sk;
    #1;
    chk("ex_accum_we", 32'(accum_we), 32'(aw));
    chk("ex_reg_we", 32'(reg_we), 32'(rw));
    chk("ex_pc", 32'(pc), 32'(exp_pc));
    tick();
    clear_alu();
  endtask

  // Skipped slot: acked word must not reach READ/EXEC.
  task automatic discard(input logic [15:0] ins, input logic [11:0] exp_pc);
    do_fetch(0, ins, exp_pc);
    chk_no_strobe("skip");
    chk("skip_fetch_req", 32'(fetch_req), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; fetch_ack = 1'b0; instr_in = 16'h0000; int_req = 1'b0;
    clear_alu();
    tick();
    tick();
    chk_no_strobe("rst");
    chk("rst_fetch_req", 32'(fetch_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_int_en", 32'(int_en), 32'd1);
    chk("rst_int_ack", 32'(int_ack), 32'd0);
    chk("rst_zc", 32'({z_flag, c_flag}), 32'd0);
    chk("rst_instr", 32'({alu_opcode, alu_direction, alu_selector, alu_operand}), 32'd0);
    reset_n = 1'b1;

    // 1: immediate ack, accum write, both flags written.
    run_instr(0, 16'h6203, 12'd0, 1, 0, 1, 1, 1, 1, 0, 0);
    chk("t1_pc", 32'(pc), 32'd1);
    chk("t1_zc", 32'({z_flag, c_flag}), 32'b11);
    chk("t1_cin", 32'(alu_cin), 32'd1);

    // 2: four fetch wait states; reg write; Z written to 0, C not written (cout=0 ignored).
    run_instr(4, 16'h1105, 12'd1, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("t2_pc", 32'(pc), 32'd2);
    chk("t2_zc", 32'({z_flag, c_flag}), 32'b01);

    // Walk to pc=5; the plain ret (D0xx) just advances.
    run_instr(0, 16'h2000, 12'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(1, 16'hD012, 12'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ret_plain_pc", 32'(pc), 32'd4);
    run_instr(0, 16'h2000, 12'd4, 0, 0, 0, 0, 0, 0, 0, 0);

    // 3: skip at pc=5 discards pc=6; next executed is pc=7.
    run_instr(0, 16'h7801, 12'd5, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t3_pc_after_skip", 32'(pc), 32'd6);
    discard(16'hFFFF, 12'd6);
    chk("t3_pc_after_discard", 32'(pc), 32'd7);
    run_instr(0, 16'h2000, 12'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 16'h2000, 12'd8, 0, 0, 0, 0, 0, 0, 0, 0);

    // 4: interrupt at pc=9; own Z write still commits.
    int_req = 1'b1;
    run_instr(0, 16'h4004, 12'd9, 1, 0, 1, 0, 1, 0, 0, 0);
    chk("t4_int_ack", 32'(int_ack), 32'd1);
    chk("t4_pc", 32'(pc), 32'd4);
    chk("t4_int_en", 32'(int_en), 32'd0);
    chk("t4_z", 32'(z_flag), 32'd1);
    // Handler: int_req still high but disabled, no nesting.
    run_instr(0, 16'h2000, 12'd4, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_nonest_pc", 32'(pc), 32'd5);
    chk("t4_nonest_ack", 32'(int_ack), 32'd0);
    // retint with int_req high: return first.
    run_instr(0, 16'hD400, 12'd5, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_ret_pc", 32'(pc), 32'd10);
    chk("t4_ret_int_en", 32'(int_en), 32'd1);
    chk("t4_ret_ack", 32'(int_ack), 32'd0);
    // Next boundary takes it; epc=11.
    run_instr(0, 16'h2000, 12'd10, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_reentry_pc", 32'(pc), 32'd4);
    chk("t4_reentry_ack", 32'(int_ack), 32'd1);
    int_req = 1'b0;
    run_instr(0, 16'hD400, 12'd4, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_ret2_pc", 32'(pc), 32'd11);

    // 5: int_req with skip at pc=11 -> entry after discarded pc=12, epc=13.
    int_req = 1'b1;
    run_instr(0, 16'h7801, 12'd11, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t5_pc", 32'(pc), 32'd12);
    chk("t5_no_ack", 32'(int_ack), 32'd0);
    chk("t5_int_en", 32'(int_en), 32'd1);
    discard(16'h1234, 12'd12);
    chk("t5_entry_pc", 32'(pc), 32'd4);
    chk("t5_entry_ack", 32'(int_ack), 32'd1);
    chk("t5_entry_int_en", 32'(int_en), 32'd0);
    int_req = 1'b0;
    run_instr(0, 16'hD400, 12'd4, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t5_ret_pc", 32'(pc), 32'd13);

    // 6: reset during EXEC of a reg-write instruction (flags are Z=1, C=1 here).
    chk("t6_pre_zc", 32'({z_flag, c_flag}), 32'b11);
    do_fetch(0, 16'h3107, 12'd13);
    tick();
    alu_reg_write = 1'b1; alu_z_write = 1'b1; alu_zout = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("t6_reg_we", 32'(reg_we), 32'd0);
    chk("t6_fetch_req", 32'(fetch_req), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_zc", 32'({z_flag, c_flag}), 32'd0);
    tick();
    clear_alu();
    tick();
    reset_n = 1'b1;
    run_instr(0, 16'h2000, 12'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_recover_pc", 32'(pc), 32'd1);

    // PC wrap: stream no-ops from pc=1 to pc=4095, then one more wraps to 0.
    fetch_ack = 1'b1;
    repeat (3 * 4094) tick();
    fetch_ack = 1'b0;
    run_instr(0, 16'h2000, 12'd4095, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", 32'(pc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
